// File: rtl/rtib_pkg.sv
// Shared widths and the FIFO word layout for the RTIB timestamping core.
package rtib_pkg;

    localparam int TS_W   = 64;
    localparam int WORD_W = 128;
    localparam int EVT_W  = 8;
    localparam int PAD_W  = WORD_W - TS_W - EVT_W;

    // Low 64 bits form the event field; channels above EVT_W spill into pad.
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [PAD_W-1:0] pad;
        logic [EVT_W-1:0] events;
    } rtib_word_t;

endpackage

// File: rtl/rtib_fifo.sv
// Show-ahead synchronous FIFO on an inferred block RAM, with a write bypass
// so a word written into an empty (or just-drained) FIFO appears next cycle.
module rtib_fifo
    import rtib_pkg::*;
#(
    parameter int  DEPTH     = 1024,
    parameter int  THRESHOLD = 1000,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  rtib_word_t    wr_data_i,
    input  logic          rd_en_i,
    output rtib_word_t    rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          wr_drop_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, push;
    logic          byp_q;
    rtib_word_t    rd_data_q, byp_data_q;
    rtib_word_t    mem [DEPTH];

    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (32'(count_q) > 32'(THRESHOLD));
    assign count_o       = count_q;

    // A pop frees the slot the simultaneous write needs, so full does not block it.
    assign pop       = rd_en_i & ~empty_o & ~flush_i;
    assign push      = wr_en_i & ~flush_i & (~full_o | pop);
    assign wr_drop_o = wr_en_i & ~flush_i & full_o & ~pop;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            byp_q    <= push && (wr_ptr_q == rd_ptr_d);
        end
    end

    // NOTE: the RAM array and its read/bypass registers carry no reset; dout is gated by empty instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
        rd_data_q  <= mem[rd_ptr_d];
        byp_data_q <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : (byp_q ? byp_data_q : rd_data_q);

endmodule

// File: rtl/rtib_core.sv
// TTL event timestamping core: synchronizers, arm counter, edge detect, error capture.
// Optional per-channel glitch filter enabled by defining RTIB_GLITCH_FILTER_EN.
module rtib_core
    import rtib_pkg::*;
#(
    parameter int  DEPTH     = 1024,
    parameter int  THRESHOLD = 1000,
    parameter int  CHANNELS  = 8,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                auto_start,
    input  logic                flush,
    input  logic [CHANNELS-1:0] ttl_in,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [TS_W-1:0]     counter,
    input  logic                rd_en,
    output logic [WORD_W-1:0]   dout,
    output logic                valid,
    output logic [CW-1:0]       count,
    output logic                almost_full,
    output logic                full,
    output logic                empty,
    output logic                overflow_error,
    output logic [WORD_W-1:0]   overflow_error_data,
    output logic                underflow_error
);

    logic [CHANNELS-1:0] s1_q, s2_q, p_q;
    logic [CHANNELS-1:0] lvl, fired;
    logic [1:0]          arm_q, arm_d;
    logic                armed;
    logic                wr_req, wr_drop;
    logic [WORD_W-TS_W-1:0] evt_field;
    rtib_word_t          wr_word, head_word;
    logic                overflow_q, underflow_q;
    rtib_word_t          ovf_data_q;

    assign armed = (arm_q == 2'd3);
    assign arm_d = armed ? arm_q : arm_q + 2'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            p_q   <= '0;
            arm_q <= '0;
        end else begin
            s1_q  <= ttl_in;
            s2_q  <= s1_q;
            p_q   <= lvl;
            arm_q <= arm_d;
        end
    end

`ifdef RTIB_GLITCH_FILTER_EN
    logic [CHANNELS-1:0] s3_q, s4_q, filt_q, stable;

    // While arming, pass s2 straight through so p and the filter settle together.
    assign stable = ~(s2_q ^ s3_q) & ~(s3_q ^ s4_q);
    assign lvl    = armed ? ((stable & s2_q) | (~stable & filt_q)) : s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_q   <= '0;
            s4_q   <= '0;
            filt_q <= '0;
        end else begin
            s3_q   <= s2_q;
            s4_q   <= s3_q;
            filt_q <= lvl;
        end
    end
`else
    assign lvl = s2_q;
`endif

    assign fired  = (rise_en & lvl & ~p_q) | (fall_en & ~lvl & p_q);
    assign wr_req = auto_start & armed & ~flush & (|fired);

    always_comb begin
        evt_field                 = '0;
        evt_field[CHANNELS-1:0]   = fired & lvl;
    end

    assign wr_word = {counter, evt_field};

    rtib_fifo #(
        .DEPTH    (DEPTH),
        .THRESHOLD(THRESHOLD)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush),
        .wr_en_i      (wr_req),
        .wr_data_i    (wr_word),
        .rd_en_i      (rd_en),
        .rd_data_o    (head_word),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .almost_full_o(almost_full),
        .wr_drop_o    (wr_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ovf_data_q  <= '0;
        end else begin
            overflow_q  <= wr_drop & ~flush;
            underflow_q <= rd_en & empty & ~flush;
            if (wr_drop) ovf_data_q <= wr_word;
        end
    end

    assign dout                = head_word;
    assign valid               = ~empty;
    assign overflow_error      = overflow_q;
    assign underflow_error     = underflow_q;
    assign overflow_error_data = ovf_data_q;

endmodule
